// File: rtl/img_binarizer.sv
// Thresholds a raster grayscale frame, majority-votes each cell into a
// 28x28 bit image, launches the classifier and latches its prediction.
module img_binarizer #(
  parameter int SRC_DIM    = 280,
  parameter int CELL       = 10,
  parameter int PIX_W      = 8,
  parameter int PIX_THRESH = 128,
  parameter int CNT_THRESH = 50
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             frame_start,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [783:0]     img_data,
  output logic             nn_start,
  input  logic             nn_resp,
  input  logic [4:0]       nn_pred,
  output logic [4:0]       pred_out,
  output logic             pred_valid,
  output logic             busy
);

  localparam int NC    = SRC_DIM / CELL;
  localparam int NB    = NC * NC;
  localparam int XW    = (CELL > 1) ? $clog2(CELL) : 1;
  localparam int CW    = $clog2(NC);
  localparam int IW    = $clog2(NB);
  localparam int ACC_W = $clog2(CELL * CELL + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAP,
    S_LAUNCH,
    S_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [XW-1:0]    xs_q, xs_d, ys_q, ys_d;
  logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;
  logic [ACC_W-1:0] acc_q [NC];
  logic [ACC_W-1:0] acc_d [NC];
  logic [NB-1:0]    img_q, img_d;
  logic [4:0]       pred_q, pred_d;
  logic             pv_q, pv_d;
  logic             start_q, start_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;

  logic             rst_fr, clr, on, last_band;
  logic [XW-1:0]    xs_c, ys_c;
  logic [CW-1:0]    cx_c, cy_c;
  logic [ACC_W-1:0] acc_c, sum;
  logic [IW-1:0]    idx;

  // A restart in CAPTURE treats the same-cycle pixel as pixel 0,
  // so the datapath sees zeroed counters that cycle.
  always_comb begin
    rst_fr    = (state_q == S_CAP) && frame_start;
    clr       = ((state_q == S_IDLE) && frame_start) || rst_fr;
    xs_c      = rst_fr ? '0 : xs_q;
    ys_c      = rst_fr ? '0 : ys_q;
    cx_c      = rst_fr ? '0 : cx_q;
    cy_c      = rst_fr ? '0 : cy_q;
    acc_c     = rst_fr ? '0 : acc_q[cx_c];
    on        = pix_data >= PIX_W'(PIX_THRESH);
    sum       = acc_c + ACC_W'(on);
    last_band = (ys_c == XW'(CELL - 1)) && (xs_c == XW'(CELL - 1));
    idx       = IW'(cy_c) * IW'(NC) + IW'(cx_c);
  end

  always_comb begin
    state_d = state_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    acc_d   = acc_q;
    img_d   = img_q;
    pred_d  = pred_q;
    pv_d    = pv_q;
    start_d = 1'b0;

    if (clr) begin
      xs_d  = '0;
      ys_d  = '0;
      cx_d  = '0;
      cy_d  = '0;
      img_d = '0;
      pv_d  = 1'b0;
      for (int j = 0; j < NC; j++) acc_d[j] = '0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (frame_start) state_d = S_CAP;
      end
      S_CAP: begin
        if (pix_valid) begin
          if (last_band) begin
            img_d[idx] = (sum >= ACC_W'(CNT_THRESH));
            acc_d[cx_c] = '0;
          end else begin
            acc_d[cx_c] = sum;
          end
          if (xs_c == XW'(CELL - 1)) begin
            xs_d = '0;
            if (cx_c == CW'(NC - 1)) begin
              cx_d = '0;
              if (ys_c == XW'(CELL - 1)) begin
                ys_d = '0;
                if (cy_c == CW'(NC - 1)) begin
                  cy_d    = '0;
                  state_d = S_LAUNCH;
                  start_d = 1'b1;
                end else begin
                  cy_d = cy_c + CW'(1);
                end
              end else begin
                ys_d = ys_c + XW'(1);
                cy_d = cy_c;
              end
            end else begin
              cx_d = cx_c + CW'(1);
              ys_d = ys_c;
              cy_d = cy_c;
            end
          end else begin
            xs_d = xs_c + XW'(1);
            cx_d = cx_c;
            ys_d = ys_c;
            cy_d = cy_c;
          end
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (nn_resp) begin
          pred_d  = nn_pred;
          pv_d    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rdy_d  = (state_d == S_CAP);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      xs_q    <= '0;
      ys_q    <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      for (int j = 0; j < NC; j++) acc_q[j] <= '0;
      img_q   <= '0;
      pred_q  <= '0;
      pv_q    <= 1'b0;
      start_q <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      acc_q   <= acc_d;
      img_q   <= img_d;
      pred_q  <= pred_d;
      pv_q    <= pv_d;
      start_q <= start_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign pix_ready  = rdy_q;
  assign img_data   = img_q;
  assign nn_start   = start_q;
  assign pred_out   = pred_q;
  assign pred_valid = pv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_img_binarizer.sv
// Directed frames on a reduced 56x56 source with 2x2 cells (still 28x28
// cells), covering thresholds, corner cell, restart and reset in WAIT.
`timescale 1ns/1ps
module tb_img_binarizer;

  localparam int SD   = 56;
  localparam int CL   = 2;
  localparam int NPIX = SD * SD;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic         frame_start = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = '0;
  logic         pix_ready;
  logic [783:0] img_data;
  logic         nn_start;
  logic         nn_resp = 1'b0;
  logic [4:0]   nn_pred = '0;
  logic [4:0]   pred_out;
  logic         pred_valid;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  logic [783:0] ones, bit0, corner, chkr;

  img_binarizer #(
    .SRC_DIM(SD),
    .CELL(CL),
    .PIX_W(8),
    .PIX_THRESH(128),
    .CNT_THRESH(2)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .frame_start(frame_start),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .img_data(img_data),
    .nn_start(nn_start),
    .nn_resp(nn_resp),
    .nn_pred(nn_pred),
    .pred_out(pred_out),
    .pred_valid(pred_valid),
    .busy(busy)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk) if (nn_start) starts++;

  task automatic chk(input string tag, input logic [783:0] got,
                     input logic [783:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix_of(input int mode, input int i);
    int r, c;
    r = i / SD;
    c = i % SD;
    case (mode)
      0: return 8'd0;
      1: return 8'd255;
      2: return (r == 0 && c == 0) ? 8'd200 :
                (r == 0 && c == 1) ? 8'd128 : 8'd127;
      3: return (r == 0 && c == 0) ? 8'd200 : 8'd127;
      4: return (r >= SD - 2 && c >= SD - 2) ? 8'd255 : 8'd0;
      default: return (((r / 2) + (c / 2)) % 2 == 0) ? 8'd255 : 8'd0;
    endcase
  endfunction

  task automatic run_frame(input int mode, input bit gap, input bit lresp,
                           input int pre, input logic [783:0] exp,
                           input logic [4:0] pred, input bit respond);
    int s0;
    @(negedge Clk);
    frame_start = 1'b1;
    @(negedge Clk);
    frame_start = 1'b0;
    chk("cap_ready", pix_ready, 1);
    chk("cap_busy", busy, 1);
    chk("cap_pv_clr", pred_valid, 0);
    s0 = starts;
    for (int k = 0; k < pre; k++) begin
      pix_valid = 1'b1;
      pix_data  = 8'd255;
      @(negedge Clk);
    end
    for (int i = 0; i < NPIX; i++) begin
      frame_start = (pre > 0) && (i == 0);
      pix_valid   = 1'b1;
      pix_data    = pix_of(mode, i);
      @(negedge Clk);
      frame_start = 1'b0;
      if (i == NPIX - 2) chk("no_early_start", starts - s0, 0);
      if (i == NPIX - 1) chk("start_lat", nn_start, 1);
      if (gap) begin
        pix_valid = 1'b0;
        @(negedge Clk);
      end
    end
    pix_valid = 1'b0;
    if (lresp) begin
      nn_resp = 1'b1;
      nn_pred = 5'd9;
      @(negedge Clk);
      nn_resp = 1'b0;
      chk("launch_resp_ign", pred_valid, 0);
    end else if (!gap) begin
      @(negedge Clk);
    end
    chk("wait_start_low", nn_start, 0);
    chk("wait_busy", busy, 1);
    chk("wait_ready", pix_ready, 0);
    chk("img", img_data, exp);
    chk("start_once", starts - s0, 1);
    if (respond) begin
      repeat (3) @(negedge Clk);
      nn_pred = pred;
      nn_resp = 1'b1;
      @(negedge Clk);
      nn_resp = 1'b0;
      chk("pred_out", pred_out, pred);
      chk("pred_valid", pred_valid, 1);
      chk("idle_busy", busy, 0);
    end
  endtask

  initial begin
    ones   = '1;
    bit0   = '0;
    bit0[0] = 1'b1;
    corner = '0;
    corner[783] = 1'b1;
    chkr   = '0;
    for (int cy = 0; cy < 28; cy++)
      for (int cx = 0; cx < 28; cx++)
        chkr[cy * 28 + cx] = ((cx + cy) % 2 == 0);

    repeat (2) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", pix_ready, 0);
    chk("rst_start", nn_start, 0);
    chk("rst_pv", pred_valid, 0);
    chk("rst_pred", pred_out, 0);
    chk("rst_img", img_data, 0);
    Rst = 1'b1;
    @(negedge Clk);

    run_frame(0, 0, 0, 0, '0,     5'd7,  1);
    run_frame(1, 0, 0, 0, ones,   5'd21, 1);
    run_frame(2, 0, 1, 0, bit0,   5'd4,  1);
    run_frame(3, 0, 0, 0, '0,     5'd30, 1);
    run_frame(5, 0, 0, 0, chkr,   5'd13, 1);
    run_frame(4, 1, 0, 0, corner, 5'd2,  1);
    run_frame(1, 0, 0, 1000, ones, 5'd17, 1);

    run_frame(1, 0, 0, 0, ones, 5'd0, 0);
    #2;
    Rst = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ready", pix_ready, 0);
    chk("arst_start", nn_start, 0);
    chk("arst_pv", pred_valid, 0);
    chk("arst_pred", pred_out, 0);
    chk("arst_img", img_data, 0);
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    nn_pred = 5'd3;
    nn_resp = 1'b1;
    @(negedge Clk);
    nn_resp = 1'b0;
    @(negedge Clk);
    chk("late_resp_pv", pred_valid, 0);
    chk("late_resp_pred", pred_out, 0);
    chk("late_resp_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
